pipe_hold_ctrl: RTL and testbench

- Consumer of the hazard unit's HOLD; owns pipeline stage registers 3..5 for the instruction-class fields (Type, SelC) that the hazard unit reads back.
- On HOLD, freezes fetch/stage 2 and injects a bubble (all-zero Type/SelC) into stage 3 while stages 3→4→5 keep draining.
- Adds a stall-state FSM with a watchdog that flags a pipeline deadlock.

---
 rtl/pipe_hold_ctrl_pkg.sv | 28 ++
 rtl/pipe_hold_ctrl_if.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 37 +++
 rtl/pipe_hold_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hold_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_hold_ctrl_pkg.sv
// rtl/pipe_hold_ctrl_pkg.sv - shared widths, Type bit map, FSM states and bubble constants
// Purpose: common definitions for pipe_hold_ctrl, its stage registers and its interface.
// Ports: none (package).
package pipe_hold_ctrl_pkg;

  localparam int TW = 7;  // Type one-hot width
  localparam int SW = 6;  // SelC width

  // Type one-hot bit map
  localparam int WR_READ  = 0;
  localparam int WR_WRITE = 1;
  localparam int R_READ   = 2;
  localparam int R_WRITE  = 3;
  localparam int C_READ   = 4;
  localparam int C_WRITE  = 5;
  localparam int JUMP     = 6;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    ERR   = 2'd2
  } hold_state_e;

  // A bubble is an instruction with no class and no destination
  localparam logic [TW-1:0] TYPE_BUBBLE = '0;
  localparam logic [SW-1:0] SELC_BUBBLE = '0;

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// rtl/pipe_hold_ctrl_if.sv - HOLD / stage-field bundle between hazard side and pipe_hold_ctrl
// Purpose: groups stall request, stage-2 inputs, stage 3..5 readback and status outputs.
// Modports:
//   master - hazard/decode side: drives HOLD, Type2, SelC2; observes everything else.
//   slave  - pipe_hold_ctrl: consumes HOLD, Type2, SelC2; drives Type3..5, SelC3..5,
//            EN1, EN2, BUBBLE, STALL_ERR (and STALL_CYCLES when HOLD_PERF_CNT_EN is defined).
// Optional: `define HOLD_PERF_CNT_EN adds STALL_CYCLES[15:0].
interface pipe_hold_ctrl_if;
  import pipe_hold_ctrl_pkg::*;

  logic          HOLD;
  logic [TW-1:0] Type2;
  logic [SW-1:0] SelC2;
  logic [TW-1:0] Type3, Type4, Type5;
  logic [SW-1:0] SelC3, SelC4, SelC5;
  logic          EN1;
  logic          EN2;
  logic          BUBBLE;
  logic          STALL_ERR;
`ifdef HOLD_PERF_CNT_EN
  logic [15:0]   STALL_CYCLES;
`endif

  modport master (
    output HOLD, Type2, SelC2,
    input  Type3, Type4, Type5, SelC3, SelC4, SelC5,
    input  EN1, EN2, BUBBLE, STALL_ERR
`ifdef HOLD_PERF_CNT_EN
    , input STALL_CYCLES
`endif
  );

  modport slave (
    input  HOLD, Type2, SelC2,
    output Type3, Type4, Type5, SelC3, SelC4, SelC5,
    output EN1, EN2, BUBBLE, STALL_ERR
`ifdef HOLD_PERF_CNT_EN
    , output STALL_CYCLES
`endif
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - one pipeline stage register for the Type/SelC fields
// Purpose: TW+SW register with async active-low clear; captures a bubble instead of d when
//          load_bubble is high.
// Ports:
//   clk         in  rising-edge clock
//   nrst        in  async active-low clear
//   load_bubble in  capture the all-zero bubble this edge
//   d_type      in  incoming Type
//   d_selc      in  incoming SelC
//   q_type      out registered Type
//   q_selc      out registered SelC
module pipe_stage_reg
  import pipe_hold_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  input  logic          load_bubble,
  input  logic [TW-1:0] d_type,
  input  logic [SW-1:0] d_selc,
  output logic [TW-1:0] q_type,
  output logic [SW-1:0] q_selc
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q_type <= TYPE_BUBBLE;
      q_selc <= SELC_BUBBLE;
    end else if (load_bubble) begin
      q_type <= TYPE_BUBBLE;
      q_selc <= SELC_BUBBLE;
    end else begin
      q_type <= d_type;
      q_selc <= d_selc;
    end
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// rtl/pipe_hold_ctrl.sv - HOLD consumer: stage 3..5 class registers, bubble injection, stall watchdog
// Purpose: freezes fetch/stage 2 on HOLD, injects bubbles into stage 3 while 3->4->5 keep
//          draining, and flags a deadlock when HOLD persists MAX_STALL consecutive cycles.
// Ports:
//   CLK  in  rising-edge clock
//   nRST in  async active-low reset
//   bus  pipe_hold_ctrl_if.slave (HOLD, Type2, SelC2 in; Type3..5, SelC3..5, EN1, EN2,
//        BUBBLE, STALL_ERR out)
// Optional: `define HOLD_PERF_CNT_EN adds the saturating STALL_CYCLES bubble counter.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  pipe_hold_ctrl_if.slave bus
);

  localparam int CW = $clog2(MAX_STALL) + 1;

  hold_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_err_q;
  logic          en;

  logic [TW-1:0] type3, type4, type5;
  logic [SW-1:0] selc3, selc4, selc5;

  // Once in ERR the pipe stays frozen regardless of HOLD
  assign en         = ~bus.HOLD & (state_q != ERR);
  assign bus.EN1    = en;
  assign bus.EN2    = en;
  assign bus.BUBBLE = ~en;

  pipe_stage_reg u_stage3 (
    .clk         (CLK),
    .nrst        (nRST),
    .load_bubble (~en),
    .d_type      (bus.Type2),
    .d_selc      (bus.SelC2),
    .q_type      (type3),
    .q_selc      (selc3)
  );

  pipe_stage_reg u_stage4 (
    .clk         (CLK),
    .nrst        (nRST),
    .load_bubble (1'b0),
    .d_type      (type3),
    .d_selc      (selc3),
    .q_type      (type4),
    .q_selc      (selc4)
  );

  pipe_stage_reg u_stage5 (
    .clk         (CLK),
    .nrst        (nRST),
    .load_bubble (1'b0),
    .d_type      (type4),
    .d_selc      (selc4),
    .q_type      (type5),
    .q_selc      (selc5)
  );

  assign bus.Type3 = type3;
  assign bus.Type4 = type4;
  assign bus.Type5 = type5;
  assign bus.SelC3 = selc3;
  assign bus.SelC4 = selc4;
  assign bus.SelC5 = selc5;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // Rises on the same edge that enters ERR; only reset clears it
      stall_err_q <= stall_err_q | (state_d == ERR);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.HOLD) begin
          state_d = STALL;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      STALL: begin
        if (!bus.HOLD) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CW'(MAX_STALL - 1)) begin
          state_d = ERR;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.STALL_ERR = stall_err_q;

`ifdef HOLD_PERF_CNT_EN
  logic [15:0] stall_cycles_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles_q <= '0;
    end else if (~en && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign bus.STALL_CYCLES = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// tb/tb_pipe_hold_ctrl.sv - self-checking bench for pipe_hold_ctrl against a queue-based model
module tb_pipe_hold_ctrl;
  import pipe_hold_ctrl_pkg::*;

  localparam int MAX_STALL = 4;

  logic CLK;
  logic nRST;

  pipe_hold_ctrl_if bus ();

  pipe_hold_ctrl #(.MAX_STALL(MAX_STALL)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stage contents as {Type, SelC} words, index 0 = stage 3
  logic [TW+SW-1:0] m_pipe [3];
  int               m_run;   // consecutive HOLD cycles seen at edges
  bit               m_err;
  int               m_perf;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_run  = 0;
    m_err  = 1'b0;
    m_perf = 0;
  endfunction

  function automatic void model_edge(input logic h, input logic [TW-1:0] t, input logic [SW-1:0] s);
    bit run_ok;
    run_ok    = !h && !m_err;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = run_ok ? {t, s} : '0;
    if (!run_ok && m_perf < 16'hFFFF) m_perf++;
    m_run = h ? m_run + 1 : 0;
    if (m_run >= MAX_STALL) m_err = 1'b1;
  endfunction

  task automatic check_comb(input logic h);
    logic exp_en;
    exp_en = !h && !m_err;
    check_val("EN1",    32'(bus.EN1),    32'(exp_en));
    check_val("EN2",    32'(bus.EN2),    32'(exp_en));
    check_val("BUBBLE", 32'(bus.BUBBLE), 32'(!exp_en));
  endtask

  task automatic check_regs();
    check_val("Type3", 32'(bus.Type3), 32'(m_pipe[0][TW+SW-1:SW]));
    check_val("Type4", 32'(bus.Type4), 32'(m_pipe[1][TW+SW-1:SW]));
    check_val("Type5", 32'(bus.Type5), 32'(m_pipe[2][TW+SW-1:SW]));
    check_val("SelC3", 32'(bus.SelC3), 32'(m_pipe[0][SW-1:0]));
    check_val("SelC4", 32'(bus.SelC4), 32'(m_pipe[1][SW-1:0]));
    check_val("SelC5", 32'(bus.SelC5), 32'(m_pipe[2][SW-1:0]));
    check_val("STALL_ERR", 32'(bus.STALL_ERR), 32'(m_err));
`ifdef HOLD_PERF_CNT_EN
    check_val("STALL_CYCLES", 32'(bus.STALL_CYCLES), 32'(m_perf));
`endif
  endtask

  // One clock: drive at negedge, optionally pulse nRST between edges, check, then edge
  task automatic cycle(input logic h, input logic [TW-1:0] t, input logic [SW-1:0] s, input bit do_rst);
    @(negedge CLK);
    bus.HOLD  = h;
    bus.Type2 = t;
    bus.SelC2 = s;
    if (do_rst) begin
      #2 nRST = 1'b0;
      #1;
      model_reset();
      check_val("rst_Type3", 32'(bus.Type3), 32'd0);
      check_val("rst_Type4", 32'(bus.Type4), 32'd0);
      check_val("rst_Type5", 32'(bus.Type5), 32'd0);
      check_val("rst_STALL_ERR", 32'(bus.STALL_ERR), 32'd0);
      #1 nRST = 1'b1;
    end else begin
      #1;
    end
    check_comb(h);
    @(posedge CLK);
    model_edge(h, t, s);
    #1;
    check_regs();
  endtask

  logic [TW-1:0] one_hot;

  initial begin
    bus.HOLD  = 1'b0;
    bus.Type2 = '0;
    bus.SelC2 = '0;
    nRST      = 1'b0;
    model_reset();
    #3;
    check_val("reset_Type3", 32'(bus.Type3), 32'd0);
    check_val("reset_SelC5", 32'(bus.SelC5), 32'd0);
    check_val("reset_EN1",   32'(bus.EN1),   32'd1);
    check_val("reset_BUBBLE", 32'(bus.BUBBLE), 32'd0);
    check_val("reset_STALL_ERR", 32'(bus.STALL_ERR), 32'd0);
    #1 nRST = 1'b1;

    // Single instruction walks 3 -> 4 -> 5
    cycle(1'b0, 7'b0001000, 6'd5, 1'b0);
    check_val("walk_Type3", 32'(bus.Type3), 32'h08);
    cycle(1'b0, 7'd0, 6'd0, 1'b0);
    check_val("walk_Type4", 32'(bus.Type4), 32'h08);
    cycle(1'b0, 7'd0, 6'd0, 1'b0);
    check_val("walk_Type5", 32'(bus.Type5), 32'h08);
    check_val("walk_SelC5", 32'(bus.SelC5), 32'd5);

    // Two-cycle load-use stall
    cycle(1'b0, 7'(1 << R_WRITE), 6'd5, 1'b0);
    cycle(1'b1, 7'(1 << R_READ),  6'd5, 1'b0);
    check_val("stall_Type3", 32'(bus.Type3), 32'd0);
    cycle(1'b1, 7'(1 << R_READ),  6'd5, 1'b0);
    cycle(1'b0, 7'(1 << R_READ),  6'd5, 1'b0);

    // Jump drain: 3 bubbles empty stages 3..5 without tripping the watchdog
    cycle(1'b0, 7'(1 << C_WRITE), 6'd1, 1'b0);
    cycle(1'b0, 7'(1 << WR_WRITE), 6'd2, 1'b0);
    cycle(1'b0, 7'(1 << R_WRITE), 6'd3, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 7'(1 << JUMP), 6'd0, 1'b0);
    check_val("drain_types", 32'(bus.Type3 | bus.Type4 | bus.Type5), 32'd0);
    check_val("drain_no_err", 32'(bus.STALL_ERR), 32'd0);
    cycle(1'b0, 7'(1 << JUMP), 6'd0, 1'b0);

    // Deadlock: 4 HOLD cycles trip the watchdog, pipe stays frozen afterwards
    for (int i = 0; i < 4; i++) cycle(1'b1, 7'(1 << C_READ), 6'd7, 1'b0);
    check_val("trip_STALL_ERR", 32'(bus.STALL_ERR), 32'd1);
    cycle(1'b0, 7'(1 << C_READ), 6'd7, 1'b0);
    check_val("err_EN1_low", 32'(bus.EN1), 32'd0);
    cycle(1'b0, 7'(1 << C_READ), 6'd7, 1'b1);
    check_val("err_cleared", 32'(bus.STALL_ERR), 32'd0);

    // Reset mid-stall restarts the count
    cycle(1'b1, 7'(1 << R_READ), 6'd4, 1'b0);
    cycle(1'b1, 7'(1 << R_READ), 6'd4, 1'b1);
    cycle(1'b1, 7'(1 << R_READ), 6'd4, 1'b0);
    cycle(1'b1, 7'(1 << R_READ), 6'd4, 1'b0);
    check_val("post_rst_no_err", 32'(bus.STALL_ERR), 32'd0);
    cycle(1'b0, 7'd0, 6'd0, 1'b0);

    // HOLD toggling every cycle never trips
    for (int i = 0; i < 10; i++) cycle(1'(i % 2 == 0), 7'(1 << (i % TW)), 6'(i), 1'b0);
    check_val("toggle_no_err", 32'(bus.STALL_ERR), 32'd0);

    // Randomized traffic with occasional long stalls and async resets
    for (int i = 0; i < 600; i++) begin
      logic h;
      one_hot = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'(1 << $urandom_range(0, TW - 1));
      h = ($urandom_range(0, 2) == 0);
      cycle(h, one_hot, 6'($urandom_range(0, 63)), ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 required");
    $fatal(1);
  end

endmodule
